dvp_8bit_tx: RTL and testbench

- Serializes a 16-bit RGB565 pixel stream onto an OV5640-style 8-bit DVP bus: vsync, href/de and an 8-bit data byte per pclk, high byte first.
- Generates full frame timing internally from parameters.
- Used as a camera emulator so the capture/8-to-16 path and downstream video pipe run in simulation and on boards without a sensor.
- Pixels are pulled from an upstream source (FIFO or pattern generator) through a valid/ready handshake.

---
 rtl/dvp_8bit_tx_if.sv | 20 ++
 rtl/dvp_8bit_tx.sv | 153 +++++++++++++++
 tb/tb_dvp_8bit_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dvp_8bit_tx_if.sv
// Pixel-stream handshake plus the 8-bit DVP bus driven by dvp_8bit_tx.
// The slave modport is the transmitter; the master modport is the pixel source / bus observer.
interface dvp_8bit_tx_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        vs_o;
  logic        de_o;
  logic [7:0]  pdata_o;

  modport master (
    output pix_data, pix_valid,
    input  pix_ready, vs_o, de_o, pdata_o
  );

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready, vs_o, de_o, pdata_o
  );
endinterface

// File: rtl/dvp_8bit_tx.sv
// OV5640-style 8-bit DVP camera emulator: frames an RGB565 pixel stream into
// vsync/href/byte timing, high byte first, pulling pixels through valid/ready.
module dvp_8bit_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int VS_LINES = 2,
  parameter int V_BACK   = 8,
  parameter int V_FRONT  = 4
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          enable,
  dvp_8bit_tx_if.slave  bus,
  output logic          frame_start,
  output logic          underflow,
  output logic          busy
);

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = (L > 1) ? $clog2(L) : 1;
  localparam int MAXL = (VS_LINES > V_BACK) ?
                        ((VS_LINES > V_ACTIVE) ? ((VS_LINES > V_FRONT) ? VS_LINES : V_FRONT)
                                               : ((V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT))
                      : ((V_BACK > V_ACTIVE) ? ((V_BACK > V_FRONT) ? V_BACK : V_FRONT)
                                             : ((V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT));
  localparam int VW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  typedef struct packed {
    logic [2:0]    st;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
  } pos_t;

  function automatic int lines_of(input logic [2:0] s);
    case (s)
      ST_VSYNC:  lines_of = VS_LINES;
      ST_VBACK:  lines_of = V_BACK;
      ST_ACTIVE: lines_of = V_ACTIVE;
      ST_VFRONT: lines_of = V_FRONT;
      default:   lines_of = 1;
    endcase
  endfunction

  // First state at or after s that owns at least one line; past VFRONT the frame ends.
  function automatic logic [2:0] seq_from(input logic [2:0] s, input logic en);
    if (V_BACK != 0 && s <= ST_VBACK)          seq_from = ST_VBACK;
    else if (V_ACTIVE != 0 && s <= ST_ACTIVE)  seq_from = ST_ACTIVE;
    else if (V_FRONT != 0 && s <= ST_VFRONT)   seq_from = ST_VFRONT;
    else                                        seq_from = en ? ST_VSYNC : ST_IDLE;
  endfunction

  function automatic pos_t next_pos(input pos_t p, input logic en);
    pos_t n;
    n = p;
    case (p.st)
      ST_IDLE: begin
        n.h  = '0;
        n.v  = '0;
        n.st = en ? ST_VSYNC : ST_IDLE;
      end
      default: begin
        if (int'(p.h) == L - 1) begin
          n.h = '0;
          if (int'(p.v) >= lines_of(p.st) - 1) begin
            n.v  = '0;
            n.st = seq_from(p.st + 3'd1, en);
          end else begin
            n.v = p.v + VW'(1);
          end
        end else begin
          n.h = p.h + HW'(1);
        end
      end
    endcase
    next_pos = n;
  endfunction

  function automatic logic is_hi_slot(input pos_t p);
    is_hi_slot = (p.st == ST_ACTIVE) && (int'(p.h) < 2 * H_ACTIVE) && !p.h[0];
  endfunction

  pos_t       pos_q, pos_d, pos_2;
  logic       vs_q, vs_d, de_q, de_d, ready_q, ready_d;
  logic       fs_q, fs_d, unf_q, unf_d, busy_q, busy_d, take;
  logic [7:0] pdata_q, pdata_d, lo_q, lo_d;

  // Outputs are registered from the next position so they line up with pos_q;
  // pix_ready looks one more cycle ahead because the byte follows the handshake.
  always_comb begin
    pos_d   = next_pos(pos_q, enable);
    pos_2   = next_pos(pos_d, enable);
    take    = ready_q & bus.pix_valid;
    vs_d    = (pos_d.st == ST_VSYNC);
    de_d    = (pos_d.st == ST_ACTIVE) && (int'(pos_d.h) < 2 * H_ACTIVE);
    fs_d    = vs_d && (pos_d.h == '0) && (pos_d.v == '0);
    busy_d  = (pos_d.st != ST_IDLE);
    ready_d = is_hi_slot(pos_2);
    unf_d   = unf_q | (ready_q & ~bus.pix_valid);
    pdata_d = 8'h00;
    lo_d    = lo_q;
    if (de_d) begin
      if (!pos_d.h[0]) begin
        pdata_d = take ? bus.pix_data[15:8] : 8'h00;
        lo_d    = take ? bus.pix_data[7:0]  : 8'h00;
      end else begin
        pdata_d = lo_q;
      end
    end else begin
      pdata_d = 8'h00;
    end
  end

  // Timing position and registered DVP outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pos_q   <= '0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      pdata_q <= 8'h00;
      lo_q    <= 8'h00;
      ready_q <= 1'b0;
      fs_q    <= 1'b0;
      unf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      pdata_q <= pdata_d;
      lo_q    <= lo_d;
      ready_q <= ready_d;
      fs_q    <= fs_d;
      unf_q   <= unf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.vs_o      = vs_q;
  assign bus.de_o      = de_q;
  assign bus.pdata_o   = pdata_q;
  assign bus.pix_ready = ready_q;
  assign frame_start   = fs_q;
  assign underflow     = unf_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dvp_8bit_tx.sv
// Directed bench for dvp_8bit_tx with a tiny frame (L=14, 84-cycle frame).
module tb_dvp_8bit_tx;
  logic        pclk;
  logic        rst;
  logic        enable;
  logic        frame_start, underflow, busy;
  logic        valid_r, solid;
  logic [15:0] pix_cnt;
  logic        unf_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          w;

  dvp_8bit_tx_if bus ();

  dvp_8bit_tx #(
    .H_ACTIVE(4), .H_BLANK(6), .V_ACTIVE(3),
    .VS_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .bus(bus),
    .frame_start(frame_start), .underflow(underflow), .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  assign bus.pix_data  = solid ? 16'hF81F : pix_cnt;
  assign bus.pix_valid = valid_r;

  // Source model: next incrementing pixel on every accepted handshake.
  always @(posedge pclk or posedge rst) begin
    if (rst) pix_cnt <= 16'h0000;
    else if (bus.pix_valid && bus.pix_ready) pix_cnt <= pix_cnt + 16'h0001;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic hi_slot_at(input int k);
    int line, h;
    line = (k % 84) / 14;
    h    = (k % 84) % 14;
    return (line >= 2 && line <= 4 && h < 8 && (h % 2) == 0);
  endfunction

  // Waits for frame_start, then checks all 84 cycles of the frame against the counting model.
  task automatic check_frame(input logic drop_en, input int drop_slot, output int waited);
    int base, line, h, s, slot_k;
    logic de_e;
    logic [15:0] p;
    logic [7:0] eb;
    waited = 0;
    do begin
      @(negedge pclk);
      waited++;
    end while (!frame_start && waited < 300);
    check_eq("frame_start_seen", {31'd0, frame_start}, 32'd1);
    base   = int'(pix_cnt);
    slot_k = (drop_slot >= 0) ? (2 + drop_slot / 4) * 14 + 2 * (drop_slot % 4) : -10;
    for (int k = 0; k < 84; k++) begin
      if (k > 0) @(negedge pclk);
      line = k / 14;
      h    = k % 14;
      s    = (line - 2) * 4 + h / 2;
      de_e = (line >= 2 && line <= 4 && h < 8);
      eb   = 8'h00;
      if (de_e) begin
        if (solid) p = 16'hF81F;
        else if (drop_slot >= 0 && s == drop_slot) p = 16'h0000;
        else p = 16'(base + s - ((drop_slot >= 0 && s > drop_slot) ? 1 : 0));
        eb = (h % 2 == 0) ? p[15:8] : p[7:0];
      end
      if (k == slot_k) unf_exp = 1'b1;
      check_eq("vs_o",        {31'd0, bus.vs_o},      {31'd0, (k < 14)});
      check_eq("de_o",        {31'd0, bus.de_o},      {31'd0, de_e});
      check_eq("pdata_o",     {24'd0, bus.pdata_o},   {24'd0, eb});
      check_eq("frame_start", {31'd0, frame_start},   {31'd0, (k == 0)});
      check_eq("busy",        {31'd0, busy},          32'd1);
      check_eq("pix_ready",   {31'd0, bus.pix_ready}, {31'd0, hi_slot_at(k + 1)});
      check_eq("underflow",   {31'd0, underflow},     {31'd0, unf_exp});
      if (k == slot_k - 1) valid_r = 1'b0;
      if (k == slot_k)     valid_r = 1'b1;
      if (drop_en && k == 40) enable = 1'b0;
    end
    check_eq("consumed", 32'(int'(pix_cnt) - base), (drop_slot >= 0) ? 32'd11 : 32'd12);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_vs"},    {31'd0, bus.vs_o},    32'd0);
    check_eq({tag, "_de"},    {31'd0, bus.de_o},    32'd0);
    check_eq({tag, "_pdata"}, {24'd0, bus.pdata_o}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, bus.pix_ready}, 32'd0);
    check_eq({tag, "_fs"},    {31'd0, frame_start}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy},        32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; valid_r = 1'b1; solid = 1'b0; unf_exp = 1'b0;
    repeat (3) @(negedge pclk);
    check_idle("reset");
    check_eq("reset_unf", {31'd0, underflow}, 32'd0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      check_idle("idle_wait");
    end

    // Three back-to-back frames with incrementing pixels.
    enable = 1'b1;
    check_frame(1'b0, -1, w);
    check_eq("first_start_latency", 32'(w), 32'd1);
    check_frame(1'b0, -1, w);
    check_eq("fs_spacing_2", 32'(w), 32'd1);
    check_frame(1'b0, -1, w);
    check_eq("fs_spacing_3", 32'(w), 32'd1);

    // Enable dropped mid-ACTIVE: frame finishes, then IDLE.
    check_frame(1'b1, -1, w);
    check_eq("fs_spacing_4", 32'(w), 32'd1);
    repeat (20) begin
      @(negedge pclk);
      check_idle("after_drop");
    end

    // Restart with a solid colour; VSYNC must follow the enable at once.
    solid  = 1'b1;
    enable = 1'b1;
    check_frame(1'b0, -1, w);
    check_eq("restart_latency", 32'(w), 32'd1);
    solid = 1'b0;

    // Second pixel of active line 1 starved.
    check_frame(1'b0, 5, w);
    check_eq("fs_spacing_6", 32'(w), 32'd1);

    // Asynchronous reset in the middle of an active line.
    w = 0;
    do begin
      @(negedge pclk);
      w++;
    end while (!frame_start && w < 300);
    check_eq("fs_before_reset", {31'd0, frame_start}, 32'd1);
    repeat (30) @(negedge pclk);
    check_eq("pre_reset_de",  {31'd0, bus.de_o}, 32'd1);
    check_eq("pre_reset_unf", {31'd0, underflow}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_idle("async_reset");
    check_eq("async_reset_unf", {31'd0, underflow}, 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge pclk);
      check_idle("post_reset");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
